param_one_counter: RTL and testbench
====================================

# param_one_counter

Parametrised, single-clock bit-population counter: on a Start request it latches a WIDTH-bit word and counts its ones (or zeros, per Mode), STEP bits per cycle, then reports the count with a one-cycle Done pulse. It succeeds the fixed 4-bit dual-clock ones counter and serves as the counting stage for the lab datapaths and the factorial/BTL control blocks, which issue Start and consume Out on Done.

## Interface
- WIDTH, 8: data word width; ≥1.
- STEP, 1: bits examined per cycle; 1 ≤ STEP ≤ WIDTH, WIDTH % STEP == 0 (elaboration error otherwise).
- OUT_W, $clog2(WIDTH+1): count width (derived, not overridden).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- Start  in  1  request; sampled only when Busy=0.
- Mode  in  1  0 = count ones, 1 = count zeros; sampled with Start.
- DataIn  in  WIDTH  operand; sampled with Start only.
- Busy  out  1  count in progress.
- Out  out  OUT_W  result; held until next completion.
- Done  out  1  one-cycle pulse, Out valid in that cycle.

## Operation
- States: IDLE, RUN (Done is a registered pulse, no separate state).
- IDLE, Start=1 at edge: shift reg ← Mode ? ~DataIn : DataIn; acc ← 0; beat ← N = WIDTH/STEP; go RUN; Busy ← 1.
- IDLE, Start=0: hold; Out keeps last result.
- RUN, each edge: acc ← acc + popcount(shift[STEP-1:0]); shift ← shift >> STEP; beat ← beat-1.
- RUN, last beat (beat==1): Out ← final acc; Done ← 1; Busy ← 0; go IDLE.
- Start while Busy=1: ignored, no queueing; DataIn/Mode changes during RUN have no effect.
- Accumulator is OUT_W bits; max value WIDTH, no overflow possible.
- Reset (RST_N=0 at edge), any state incl. mid-RUN: state IDLE, Busy=0, Done=0, Out=0, acc=0, shift=0, beat=0; in-flight count discarded, no Done.

## Timing
- Reset values: Busy=0, Done=0, Out=0.
- Start sampled at edge k → Busy high from k to k+N; Done high for exactly the cycle after edge k+N; Out updates at edge k+N.
- Latency fixed N = WIDTH/STEP cycles, data-independent.
- Back-to-back: Start high during the Done cycle is accepted at the next edge (IDLE); throughput one result per N+1 cycles... more precisely next Done at k+2N+1... — Start at edge k+N+1 gives Done after edge k+2N+1.
- Done never asserts without a preceding accepted Start; never two consecutive cycles.
- RST_N deassertion takes effect at first edge sampling 1; Start on that same edge is accepted.

## Structure
- Package param_one_counter_pkg: state encoding constants (IDLE, RUN); out_width(WIDTH) helper returning $clog2(WIDTH+1).
- Sub-module one_counter_slice: combinational STEP-bit popcount, output $clog2(STEP+1) bits; one instance in the datapath.
- Top: FSM, shift register, beat counter (width $clog2(N+1)), accumulator, Out register.

## Test plan
- WIDTH=4, STEP=1, Mode=0, DataIn=4'b1010, Start one cycle → Busy 4 cycles, Done pulse after edge k+4, Out=2.
- WIDTH=8, STEP=2, Mode=1, DataIn=8'hF0 → Done after edge k+4, Out=4; DataIn=8'h00, Mode=1 → Out=8.
- WIDTH=8, STEP=8, Mode=0, DataIn=8'hFF → Done after edge k+1, Out=8; DataIn=8'h00 → Out=0.
- WIDTH=8, STEP=1: Start held continuously with DataIn toggling during RUN → only word at accepted edge counted; second Start accepted in Done cycle, results 8'h0F→4 then new word counted correctly.
- WIDTH=8, STEP=1: RST_N low for one edge at cycle 3 of RUN → Busy=0, Out=0, no Done pulse; fresh Start then completes normally.
- Randomised WIDTH∈{4,8,16}, STEP divisors, 200 words vs $countones reference → all Out match, latency always N.

Source files
------------

// File: rtl/param_one_counter_pkg.sv
// Shared definitions for the parametrised bit-population counter.
// State encoding and the result-width helper live here.
package param_one_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int out_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/one_counter_slice.sv
// Combinational popcount of one STEP-bit beat.
// Result is wide enough to hold STEP itself.
module one_counter_slice #(
    parameter int STEP = 1,
    parameter int CW   = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] bits_i,
    output logic [CW-1:0]   count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < STEP; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/param_one_counter.sv
// Multi-cycle ones/zeros counter: latches a word on Start, consumes
// STEP bits per cycle and pulses Done with the count after WIDTH/STEP beats.
module param_one_counter
    import param_one_counter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int OUT_W = out_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] DataIn,
    output logic             Busy,
    output logic [OUT_W-1:0] Out,
    output logic             Done
);

    localparam int N  = WIDTH / STEP;
    localparam int BW = $clog2(N + 1);
    localparam int CW = $clog2(STEP + 1);

    if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_cfg
        $error("param_one_counter: illegal WIDTH/STEP combination");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic               done_q, done_d;
    logic [CW-1:0]      slice_cnt;
    logic [OUT_W-1:0]   acc_sum;
    logic               last_beat;

    one_counter_slice #(
        .STEP (STEP),
        .CW   (CW)
    ) u_slice (
        .bits_i  (shift_q[STEP-1:0]),
        .count_o (slice_cnt)
    );

    assign acc_sum   = acc_q + OUT_W'(slice_cnt);
    assign last_beat = (beat_q == BW'(1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start) state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero counting is done by inverting the word once at load time.
    always_comb begin
        shift_d = shift_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        out_d   = out_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    shift_d = Mode ? ~DataIn : DataIn;
                    acc_d   = '0;
                    beat_d  = BW'(N);
                end
            end
            ST_RUN: begin
                acc_d   = acc_sum;
                shift_d = shift_q >> STEP;
                beat_d  = beat_q - BW'(1);
                if (last_beat) begin
                    out_d  = acc_sum;
                    done_d = 1'b1;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        Busy = (state_q == ST_RUN);
        Out  = out_q;
        Done = done_q;
    end

endmodule

// File: tb/tb_param_one_counter.sv
// Bench for param_one_counter across several WIDTH/STEP configurations.
// Each configuration has its own DUT, reference model and stimulus.
module tb_param_one_counter;

    localparam int NC = 8;

    function automatic int w_of(input int g);
        case (g)
            0: return 4;  1: return 8;  2: return 8;  3: return 8;
            4: return 16; 5: return 16; 6: return 4;  default: return 16;
        endcase
    endfunction

    function automatic int s_of(input int g);
        case (g)
            0: return 1;  1: return 2;  2: return 8;  3: return 1;
            4: return 4;  5: return 1;  6: return 2;  default: return 16;
        endcase
    endfunction

    typedef struct {
        int g;
        bit md;
        int d;
        int ex;
    } vec_t;

    vec_t vecs[10] = '{
        '{0, 1'b0, 'hA,    2},
        '{1, 1'b1, 'hF0,   4},
        '{1, 1'b1, 'h00,   8},
        '{2, 1'b0, 'hFF,   8},
        '{2, 1'b0, 'h00,   0},
        '{3, 1'b0, 'h0F,   4},
        '{4, 1'b0, 'hF00F, 8},
        '{5, 1'b1, 'h0001, 15},
        '{6, 1'b1, 'h7,    1},
        '{7, 1'b1, 'hFFFF, 0}
    };

    logic clk = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n_fin  = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input int g,
                         input logic [31:0] act, input int ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cfg%0d: got %0d expected %0d", nm, g, act, ex);
        end
    endtask

    for (genvar g = 0; g < NC; g++) begin : cfg
        localparam int W  = w_of(g);
        localparam int S  = s_of(g);
        localparam int N  = W / S;
        localparam int OW = $clog2(W + 1);

        logic          rst_n, start, mode;
        logic [W-1:0]  din;
        logic          busy, done;
        logic [OW-1:0] out;
        bit            chk_en = 1'b0;

        param_one_counter #(
            .WIDTH (W),
            .STEP  (S)
        ) dut (
            .CLK    (clk),
            .RST_N  (rst_n),
            .Start  (start),
            .Mode   (mode),
            .DataIn (din),
            .Busy   (busy),
            .Out    (out),
            .Done   (done)
        );

        // Reference: a request is a pending result that matures N edges later.
        bit m_busy = 1'b0;
        bit m_done = 1'b0;
        int m_left = 0;
        int m_res  = 0;
        int m_out  = 0;
        int m_acc  = 0;

        always @(posedge clk) begin
            if (rst_n !== 1'b1) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_left = 0;
                m_out  = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_out  = m_res;
                    end
                end else if (start) begin
                    m_busy = 1'b1;
                    m_left = N;
                    m_res  = mode ? W - $countones(din) : $countones(din);
                    m_acc++;
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check("busy", g, busy, m_busy);
                check("done", g, done, m_done);
                check("out",  g, out,  m_out);
            end
        end

        task automatic run_lit(input bit md, input int d, input int ex,
                               input string nm);
            int lat;
            @(negedge clk);
            start = 1'b1;
            mode  = md;
            din   = W'(d);
            @(negedge clk);
            start = 1'b0;
            mode  = ~md;
            din   = ~din;
            lat   = 1;
            while (!done && lat < N + 3) begin
                @(negedge clk);
                lat++;
                din = W'($urandom);
            end
            check({nm, "_lat"}, g, lat, N + 1);
            check({nm, "_out"}, g, out, ex);
        endtask

        initial begin : stim
            int lat;
            int rl;
            int cyc;
            rst_n = 1'b0;
            start = 1'b0;
            mode  = 1'b0;
            din   = '0;
            @(posedge clk);
            #1 chk_en = 1'b1;
            @(negedge clk);
            check("rst_out",  g, out,  0);
            check("rst_busy", g, busy, 0);
            check("rst_done", g, done, 0);
            rst_n = 1'b1;

            foreach (vecs[i]) begin
                if (vecs[i].g == g) run_lit(vecs[i].md, vecs[i].d, vecs[i].ex, "dir");
            end

            // Start held high with the word changing underneath it.
            @(negedge clk);
            start = 1'b1;
            mode  = 1'b0;
            din   = W'(32'h3333_3333);
            lat   = 0;
            do begin
                @(negedge clk);
                lat++;
                if (!done) begin
                    mode = 1'($urandom);
                    din  = W'($urandom);
                end
            end while (!done && lat < N + 3);
            check("b2b1_lat", g, lat, N + 1);
            check("b2b1_out", g, out, W / 2);
            mode = 1'b0;
            din  = W'(1);
            lat  = 0;
            do begin
                @(negedge clk);
                lat++;
                if (!done) begin
                    mode = 1'($urandom);
                    din  = W'($urandom);
                end
            end while (!done && lat < N + 3);
            start = 1'b0;
            check("b2b2_lat", g, lat, N + 1);
            check("b2b2_out", g, out, 1);

            // Reset in the middle of a count.
            @(negedge clk);
            start = 1'b1;
            mode  = 1'b1;
            din   = W'(32'h5A5A_5A5A);
            rl    = (N >= 4) ? 3 : 1;
            for (int c = 0; c < rl; c++) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midrst_busy", g, busy, 0);
            check("midrst_out",  g, out,  0);
            check("midrst_done", g, done, 0);
            run_lit(1'b0, 3, 2, "rec");

            // Random traffic, including occasional resets.
            m_acc = 0;
            cyc   = 0;
            while (m_acc < 200 && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                start = ($urandom_range(0, 2) != 0);
                mode  = 1'($urandom);
                din   = W'($urandom);
                rst_n = ($urandom_range(0, 299) != 0);
            end
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            repeat (N + 3) @(negedge clk);
            n_fin++;
        end
    end

    initial begin : main
        int cyc;
        cyc = 0;
        while (n_fin < NC && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (n_fin < NC) begin
            errors++;
            checks++;
            $display("FAIL timeout: got %0d finished expected %0d", n_fin, NC);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
